cdb_arbiter: RTL and testbench

- Round-robin arbiter for the single common data bus (CDB) of the rv32im out-of-order core.
- Shares the bus among the functional units: ALU, multiplier, divider and load/store unit.
- Grants at most one completed result per cycle and registers it onto the CDB. Reservation stations, ROB and the physical register file consume the CDB.
- Honours a pipeline flush.

---
 rtl/cdb_arbiter.sv | 86 ++++++++
 tb/tb_cdb_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one functional-unit result per
// cycle and registers it onto the CDB; honours a pipeline flush and synchronous reset.
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 5,
  parameter int PHYS_W    = 6,
  parameter int DATA_W    = 32,
  localparam int SRC_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]  req_rob_idx,
  input  logic [NUM_REQ*PHYS_W-1:0]     req_pd,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          cdb_valid,
  output logic [ROB_IDX_W-1:0]          cdb_rob_idx,
  output logic [PHYS_W-1:0]             cdb_pd,
  output logic [DATA_W-1:0]             cdb_data,
  output logic [SRC_W-1:0]              cdb_src
);

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_found;
  logic [SRC_W:0]   scan_idx;
  logic             scan_hit;
  logic             xfer;
  logic [SRC_W-1:0] ptr_next;

  // First valid requester at or after ptr, wrapping; the extra bit absorbs ptr+k overflow.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    scan_hit    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr} + (SRC_W+1)'(k);
      if (scan_idx >= (SRC_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (SRC_W+1)'(NUM_REQ);
      end else begin
        scan_idx = scan_idx;
      end
      scan_hit    = req_valid[scan_idx[SRC_W-1:0]] & ~grant_found;
      grant_idx   = scan_hit ? scan_idx[SRC_W-1:0] : grant_idx;
      grant_found = grant_found | scan_hit;
    end
  end

  // Grant is suppressed during reset and flush so nothing transfers in those cycles.
  always_comb begin
    req_ready = '0;
    if (grant_found && !flush && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign xfer     = |(req_valid & req_ready);
  assign ptr_next = (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + SRC_W'(1);

  // Pointer and CDB output register; payload holds its last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_pd      <= '0;
      cdb_data    <= '0;
      cdb_src     <= '0;
    end else if (xfer) begin
      ptr         <= ptr_next;
      cdb_valid   <= 1'b1;
      cdb_rob_idx <= req_rob_idx[grant_idx*ROB_IDX_W +: ROB_IDX_W];
      cdb_pd      <= req_pd[grant_idx*PHYS_W +: PHYS_W];
      cdb_data    <= req_data[grant_idx*DATA_W +: DATA_W];
      cdb_src     <= grant_idx;
    end else begin
      cdb_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// compared against a round-robin reference model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int RW = 5;
  localparam int PW = 6;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*RW-1:0] req_rob_idx;
  logic [N*PW-1:0] req_pd;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [RW-1:0]   cdb_rob_idx;
  logic [PW-1:0]   cdb_pd;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .ROB_IDX_W(RW), .PHYS_W(PW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_rob_idx(req_rob_idx), .req_pd(req_pd), .req_data(req_data),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx),
    .cdb_pd(cdb_pd), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  // Requester protocol: an ungranted request stays valid and stable unless flushed.
  for (genvar i = 0; i < N; i++) begin : g_rules
    assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i] && !flush) |=> req_valid[i])
      else $error("FAIL rule_hold_valid unit %0d", i);
    assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i] && !flush) |=>
        $stable({req_rob_idx[i*RW +: RW], req_pd[i*PW +: PW], req_data[i*DW +: DW]}))
      else $error("FAIL rule_hold_payload unit %0d", i);
  end

  int errors = 0;
  int checks = 0;

  // reference model state
  int            m_ptr;
  logic          m_valid;
  logic [RW-1:0] m_rob;
  logic [PW-1:0] m_pd;
  logic [DW-1:0] m_data;
  logic [1:0]    m_src;

  function automatic int model_grant();
    if (rst || flush) return -1;
    for (int i = 0; i < N; i++) if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    int g;
    g = model_grant();
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_valid = 1'b0; m_rob = '0; m_pd = '0; m_data = '0; m_src = '0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_rob   = req_rob_idx[g*RW +: RW];
      m_pd    = req_pd[g*PW +: PW];
      m_data  = req_data[g*DW +: DW];
      m_src   = 2'(g);
      m_ptr   = (g + 1) % N;
    end else begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic set_unit(input int i, input logic v, input logic [RW-1:0] r,
                          input logic [PW-1:0] p, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_rob_idx[i*RW +: RW] = r;
    req_pd[i*PW +: PW]      = p;
    req_data[i*DW +: DW]    = d;
  endtask

  task automatic drain();
    int g;
    int budget;
    budget = 20;
    while (|req_valid && budget > 0) begin
      g = model_grant();
      tick();
      if (g >= 0) req_valid[g] = 1'b0;
      budget--;
    end
    checks++;
    if (req_valid !== '0) begin
      errors++;
      $display("FAIL drain_timeout: valid=%b required=0", req_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    for (int i = 0; i < N; i++)
      set_unit(i, 1'b1, RW'(i + 1), PW'(i + 10), 32'hA000_0000 + DW'(i));
    tick(); tick();
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b required 0000", req_ready);
    end
    checks++;
    if ({cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src} !== '0) begin
      errors++;
      $display("FAIL reset_cdb: valid=%b rob=%0d pd=%0d data=%h src=%0d required all 0",
               cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src);
    end
    rst = 1'b0;
  endtask

  task automatic test_contention();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << (c % N))) begin
        errors++; $display("FAIL contention_ready c=%0d: got %b required %b", c, req_ready, 4'(1 << (c % N)));
      end
      checks++;
      if (c == 0 && cdb_valid !== 1'b0) begin
        errors++; $display("FAIL contention_first_idle: cdb_valid=%b required 0", cdb_valid);
      end else if (c > 0 && (cdb_valid !== 1'b1 || cdb_src !== 2'((c - 1) % N) || cdb_data !== m_data)) begin
        errors++;
        $display("FAIL contention_cdb c=%0d: valid=%b src=%0d data=%h required 1 %0d %h",
                 c, cdb_valid, cdb_src, cdb_data, (c - 1) % N, m_data);
      end
      tick();
      set_unit(c % N, 1'b1, RW'(c + 20), PW'(c + 30), 32'hB000_0000 + DW'(c));
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL midreset_ready: got %b required 0000", req_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src} !== '0) begin
      errors++;
      $display("FAIL midreset_cdb: valid=%b rob=%0d pd=%0d data=%h src=%0d required all 0",
               cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src);
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midreset_regrant: got %b required 0001", req_ready);
    end
    drain();
  endtask

  task automatic test_single();
    tick();
    set_unit(2, 1'b1, 5'd7, 6'd12, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b required 0100", req_ready);
    end
    tick();
    req_valid[2] = 1'b0;
    #1;
    checks++;
    if ({cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src} !== {1'b1, 5'd7, 6'd12, 32'hDEAD_BEEF, 2'd2}) begin
      errors++;
      $display("FAIL single_cdb: valid=%b rob=%0d pd=%0d data=%h src=%0d required 1 7 12 deadbeef 2",
               cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src);
    end
    checks++;
    if (dut.ptr !== 2'd3) begin
      errors++; $display("FAIL single_ptr: got %0d required 3", dut.ptr);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle: cdb_valid=%b required 0", cdb_valid);
    end
  endtask

  task automatic test_wrap();
    set_unit(0, 1'b1, 5'd1, 6'd2, 32'h0000_1000);
    set_unit(1, 1'b1, 5'd3, 6'd4, 32'h0000_1001);
    for (int s = 0; s < 2; s++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << s)) begin
        errors++; $display("FAIL wrap_ready s=%0d: got %b required %b", s, req_ready, 4'(1 << s));
      end
      tick();
      req_valid[s] = 1'b0;
      checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== 2'(s) || dut.ptr !== 2'(s + 1)) begin
        errors++;
        $display("FAIL wrap_cdb s=%0d: valid=%b src=%0d ptr=%0d required 1 %0d %0d",
                 s, cdb_valid, cdb_src, dut.ptr, s, s + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 1; s <= 3; s++) begin
      set_unit(1, 1'b1, RW'(s), PW'(s), DW'(s));
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
        errors++; $display("FAIL b2b_ready s=%0d: got %b required 0010", s, req_ready);
      end
      tick();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_data !== DW'(s) || cdb_src !== 2'd1) begin
        errors++;
        $display("FAIL b2b_cdb s=%0d: valid=%b data=%0d src=%0d required 1 %0d 1", s, cdb_valid, cdb_data, cdb_src, s);
      end
    end
    req_valid[1] = 1'b0;
  endtask

  task automatic test_flush();
    set_unit(0, 1'b1, 5'd9, 6'd0, 32'h1234_5678);
    set_unit(3, 1'b1, 5'd10, 6'd33, 32'h8765_4321);
    flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL flush_ready: got %b required 0000", req_ready);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (cdb_valid !== 1'b0 || dut.ptr !== 2'd2) begin
      errors++; $display("FAIL flush_after: cdb_valid=%b ptr=%0d required 0 2", cdb_valid, dut.ptr);
    end
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL flush_resume: got %b required 1000", req_ready);
    end
    tick();
    req_valid[3] = 1'b0;
    tick();
    req_valid[0] = 1'b0;
    checks++;
    if ({cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src} !== {1'b1, 5'd9, 6'd0, 32'h1234_5678, 2'd0}) begin
      errors++;
      $display("FAIL pd_zero_cdb: valid=%b rob=%0d pd=%0d data=%h src=%0d required 1 9 0 12345678 0",
               cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src);
    end
  endtask

  task automatic test_random();
    int g;
    logic prev_flush;
    prev_flush = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(1, 0) == 1)
          set_unit(i, 1'b1, RW'($urandom), PW'($urandom), DW'($urandom));
      flush = !prev_flush && ($urandom_range(7, 0) == 0);
      prev_flush = flush;
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++; $display("FAIL random_ready c=%0d: got %b required %b", c, req_ready, exp_ready());
      end
      checks++;
      if (cdb_valid !== m_valid ||
          (m_valid && {cdb_rob_idx, cdb_pd, cdb_data, cdb_src} !== {m_rob, m_pd, m_data, m_src})) begin
        errors++;
        $display("FAIL random_cdb c=%0d: valid=%b rob=%0d pd=%0d data=%h src=%0d required %b %0d %0d %h %0d",
                 c, cdb_valid, cdb_rob_idx, cdb_pd, cdb_data, cdb_src, m_valid, m_rob, m_pd, m_data, m_src);
      end
      g = model_grant();
      tick();
      if (g >= 0) req_valid[g] = 1'b0;
    end
    flush = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    req_valid = '0; req_rob_idx = '0; req_pd = '0; req_data = '0;
    test_reset();
    test_contention();
    test_single();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
